mem_access_unit: RTL and testbench

- MEM-stage data-bus controller, directly downstream of the EX/MEM pipeline register; consumes its mem_ctrl, result, reg2 data, wb_ctrl and Rd outputs.
- Runs a req/ack transaction on the data bus for loads and stores. Builds byte enables and aligned write data, and sign/zero-extends load data.
- Requests a pipeline hold while the transaction is in flight.
- Presents write-back data and controls to the MEM/WB register.

---
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-bus bundle between the MEM-stage access unit and data memory.
// Single-cycle d_ack completes a req/ack transaction.
interface mem_access_unit_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata
  );

  modport slave (
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-bus controller: req/ack loads/stores, lane steering, hold.
// Optional MEM_MISALIGN_CHECK_EN: misaligned H/W trap via misalign_o.
module mem_access_unit #(
  parameter int unsigned BUS_TIMEOUT = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        flag_flush,
  input  logic [14:0] mem_ctrl_i,
  input  logic [31:0] result_i,
  input  logic [31:0] reg2_r_data_i,
  input  logic [1:0]  wb_ctrl_i,
  input  logic [4:0]  mem_Rd_i,
  input  logic [31:0] inst_addr_i,
  mem_access_unit_if.master bus,
  output logic        hold_req_o,
  output logic [31:0] wb_data_o,
  output logic [1:0]  wb_ctrl_o,
  output logic [4:0]  mem_Rd_o,
  output logic [31:0] inst_addr_o,
  output logic        bus_err_o
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_n;

  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] load_data;
  logic [7:0]  cnt;
  logic        kill;
  logic        err_q;

  logic [2:0]  f3;
  logic [1:0]  a;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        acc_raw;
  logic        mis;
  logic        acc;
  logic        tmo;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rsh;
  logic [15:0] half;
  logic [31:0] ld_ext;

  logic unused;
  assign unused = ^mem_ctrl_i[14:5];

  assign f3   = mem_ctrl_i[4:2];
  assign a    = result_i[1:0];
  assign is_b = (f3[1:0] == 2'b00);
  assign is_h = (f3[1:0] == 2'b01);
  assign is_w = ~is_b & ~is_h;

  assign acc_raw = (mem_ctrl_i[0] | mem_ctrl_i[1]) & ~flag_flush;

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis = acc_raw & (state == IDLE) &
               ((is_h & a[0]) | (is_w & (|a)));
  assign misalign_o = mis;
`else
  assign mis = 1'b0;
`endif

  assign acc = acc_raw & ~mis;
  assign tmo = (cnt == 8'(BUS_TIMEOUT - 1));

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = reg2_r_data_i;
    unique case (1'b1)
      is_b: begin
        be_c    = 4'b0001 << a;
        wdata_c = {4{reg2_r_data_i[7:0]}};
      end
      is_h: begin
        be_c    = a[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{reg2_r_data_i[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = reg2_r_data_i;
      end
    endcase
  end

  // Lane select uses the live address: EX/MEM is frozen while we hold.
  assign rsh  = bus.d_rdata >> {a, 3'b000};
  assign half = a[1] ? bus.d_rdata[31:16] : bus.d_rdata[15:0];

  always_comb begin
    ld_ext = bus.d_rdata;
    unique case (1'b1)
      is_b:
        ld_ext = f3[2] ? {24'd0, rsh[7:0]}
                       : {{24{rsh[7]}}, rsh[7:0]};
      is_h:
        ld_ext = f3[2] ? {16'd0, half}
                       : {{16{half[15]}}, half};
      default:
        ld_ext = bus.d_rdata;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (acc) state_n = REQ;
      REQ:  if (bus.d_ack | tmo) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      load_data <= 32'd0;
      cnt       <= 8'd0;
      kill      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (acc) begin
            req_q   <= 1'b1;
            we_q    <= mem_ctrl_i[1];
            addr_q  <= {result_i[31:2], 2'b00};
            be_q    <= be_c;
            wdata_q <= wdata_c;
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (flag_flush) kill <= 1'b1;
          if (bus.d_ack) begin
            load_data <= ld_ext;
            req_q     <= 1'b0;
          end else if (tmo) begin
            load_data <= 32'd0;
            req_q     <= 1'b0;
            err_q     <= 1'b1;
            kill      <= 1'b1;
          end
        end
        RESP: begin
          cnt  <= 8'd0;
          kill <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.d_req   = req_q;
  assign bus.d_we    = we_q;
  assign bus.d_addr  = addr_q;
  assign bus.d_wdata = wdata_q;
  assign bus.d_be    = be_q;

  assign hold_req_o  = ((state == IDLE) & acc) | (state == REQ);
  assign wb_data_o   = ((state == RESP) & wb_ctrl_i[1]) ? load_data
                                                        : result_i;
  assign wb_ctrl_o   = (kill | flag_flush | mis) ? 2'b00 : wb_ctrl_i;
  assign mem_Rd_o    = mem_Rd_i;
  assign inst_addr_o = inst_addr_i;
  assign bus_err_o   = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random accesses vs a lane model.
// Bus responder driven from the bench; BUS_TIMEOUT shortened to 4.
module tb_mem_access_unit;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [14:0] mem_ctrl;
  logic [31:0] result;
  logic [31:0] reg2;
  logic [1:0]  wb_ctrl;
  logic [4:0]  rd;
  logic [31:0] ia;
  logic        ack;
  logic [31:0] rdat;
  logic        hold;
  logic [31:0] wb_data;
  logic [1:0]  wb_ctrl_q;
  logic [4:0]  rd_q;
  logic [31:0] ia_q;
  logic        bus_err;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();
  assign bus.d_ack   = ack;
  assign bus.d_rdata = rdat;

  mem_access_unit #(.BUS_TIMEOUT(T)) dut (
    .sys_clk       (clk),
    .sys_rst       (rst),
    .flag_flush    (flush),
    .mem_ctrl_i    (mem_ctrl),
    .result_i      (result),
    .reg2_r_data_i (reg2),
    .wb_ctrl_i     (wb_ctrl),
    .mem_Rd_i      (rd),
    .inst_addr_i   (ia),
    .bus           (bus),
    .hold_req_o    (hold),
    .wb_data_o     (wb_data),
    .wb_ctrl_o     (wb_ctrl_q),
    .mem_Rd_o      (rd_q),
    .inst_addr_o   (ia_q),
    .bus_err_o     (bus_err)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .misalign_o    (misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes; undefined encodings behave as words.
  function automatic int size_of(input logic [2:0] f);
    if (f == 3'b000 || f == 3'b100) return 1;
    if (f == 3'b001 || f == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] mask_of(input int size);
    longint m;
    m = (64'd1 << (8 * size)) - 1;
    return m[31:0];
  endfunction

  function automatic int off_of(input logic [2:0] f, input logic [31:0] ad);
    int lo;
    lo = int'(ad[1:0]);
    return lo - (lo % size_of(f));
  endfunction

  function automatic logic [31:0] ref_be(input logic [2:0] f,
                                         input logic [31:0] ad);
    int sz;
    sz = size_of(f);
    return ((32'd1 << sz) - 32'd1) << off_of(f, ad);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f,
                                            input logic [31:0] d);
    int sz;
    logic [31:0] r;
    logic [31:0] u;
    sz = size_of(f);
    u  = d & mask_of(sz);
    r  = 32'd0;
    for (int i = 0; i < 4 / sz; i++) r = r | (u << (8 * sz * i));
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f,
                                           input logic [31:0] ad,
                                           input logic [31:0] d);
    int sz;
    logic [31:0] v;
    logic [31:0] m;
    sz = size_of(f);
    m  = mask_of(sz);
    v  = (d >> (8 * off_of(f, ad))) & m;
    if (sz < 4 && !f[2] && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  task automatic run_acc(input bit ld, input bit st, input logic [2:0] f,
                         input logic [31:0] ad, input logic [31:0] sd,
                         input logic [31:0] rv, input int wt,
                         input int fc);
    int c;
    int holds;
    int resp_c;
    bit to;
    bit supp;
    bit killed;
    logic [1:0] wbc;
    to     = (wt < 0) || (wt >= T);
    resp_c = to ? T + 1 : wt + 2;
    supp   = (fc == 0);
    killed = to || (fc >= 1 && fc <= resp_c);
    wbc    = st ? 2'b00 : 2'b11;
    @(posedge clk); #1;
    mem_ctrl = {10'd0, f, st, ld};
    result   = ad;
    reg2     = sd;
    wb_ctrl  = wbc;
    rd       = 5'($urandom);
    ia       = $urandom;
    holds    = 0;
    for (c = 0; c < 40; c++) begin
      ack   = !supp && wt >= 0 && c == wt + 1;
      rdat  = ack ? rv : $urandom;
      flush = (c == fc);
      @(negedge clk);
      if (hold) holds++;
      if (c == 1) begin
        chk("d_req", 32'(bus.d_req), 32'd1);
        chk("d_we", 32'(bus.d_we), 32'(st));
        chk("d_addr", bus.d_addr, {ad[31:2], 2'b00});
        chk("d_be", 32'(bus.d_be), ref_be(f, ad));
        chk("d_wdata", bus.d_wdata, ref_wdata(f, sd));
      end
      if (!hold) break;
      @(posedge clk); #1;
    end
    chk("hold_cycles", holds, supp ? 0 : resp_c);
    if (supp) begin
      chk("flush_idle_req", 32'(bus.d_req), 32'd0);
      chk("flush_idle_wbctrl", 32'(wb_ctrl_q), 32'd0);
    end else begin
      chk("resp_req", 32'(bus.d_req), 32'd0);
      chk("bus_err", 32'(bus_err), 32'(to));
      chk("wb_ctrl", 32'(wb_ctrl_q), killed ? 32'd0 : 32'(wbc));
      if (ld && !st)
        chk("wb_data", wb_data, to ? 32'd0 : ref_load(f, ad, rv));
      else
        chk("wb_data_st", wb_data, ad);
      chk("rd_pass", 32'(rd_q), 32'(rd));
      chk("ia_pass", ia_q, ia);
    end
    @(posedge clk); #1;
    mem_ctrl = 15'd0;
    flush    = 1'b0;
    ack      = 1'b0;
    @(negedge clk);
    chk("post_err", 32'(bus_err), 32'd0);
    chk("post_hold", 32'(hold), 32'd0);
  endtask

  logic [2:0] f3s [8];

  initial begin
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
    rst = 1'b1; flush = 1'b0; mem_ctrl = 15'd0; result = 32'd0;
    reg2 = 32'd0; wb_ctrl = 2'd0; rd = 5'd0; ia = 32'd0;
    ack = 1'b0; rdat = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.d_req), 32'd0);
    chk("rst_we", 32'(bus.d_we), 32'd0);
    chk("rst_be", 32'(bus.d_be), 32'd0);
    chk("rst_addr", bus.d_addr, 32'd0);
    chk("rst_wdata", bus.d_wdata, 32'd0);
    chk("rst_hold", 32'(hold), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_acc(1, 0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, -1);
    chk("lw_value", wb_data, 32'h0000_0100);
    run_acc(1, 0, 3'b000, 32'h203, 32'd0, 32'h80FF_FF7F, 0, -1);
    run_acc(1, 0, 3'b100, 32'h203, 32'd0, 32'h80FF_FF7F, 1, -1);
    run_acc(0, 1, 3'b001, 32'h302, 32'h1234ABCD, 32'd0, 3, -1);
    run_acc(1, 0, 3'b010, 32'h400, 32'd0, 32'h1111_2222, -1, -1);
    run_acc(1, 0, 3'b010, 32'h500, 32'd0, 32'h3333_4444, 1, 0);
    run_acc(1, 0, 3'b101, 32'h602, 32'd0, 32'h8001_7FFF, 2, 1);
    run_acc(1, 1, 3'b000, 32'h701, 32'h0000_00A5, 32'd0, 0, -1);

    for (int i = 0; i < 60; i++) begin
      bit ld;
      bit st;
      int wt;
      int fc;
      int sel;
      sel = int'($urandom_range(0, 2));
      ld  = (sel != 1);
      st  = (sel != 0);
      wt  = int'($urandom_range(0, 6)) - 1;
      fc  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_acc(ld, st, f3s[$urandom_range(0, 7)], $urandom, $urandom,
              $urandom, wt, fc);
    end

    @(posedge clk); #1;
    mem_ctrl = {10'd0, 3'b010, 1'b0, 1'b1};
    wb_ctrl  = 2'b11;
    result   = 32'h800;
    ack      = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_req", 32'(bus.d_req), 32'd1);
    @(posedge clk); #1;
    rst      = 1'b1;
    mem_ctrl = 15'd0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_req", 32'(bus.d_req), 32'd0);
    chk("mid_rst_hold", 32'(hold), 32'd0);
    chk("mid_rst_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_req", 32'(bus.d_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
